// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared types and constants for the multicycle MIPS core.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    // Main controller states; FETCH_INSTR pairs with fetch_req on the fetch unit.
    typedef enum logic [3:0] {
        FETCH_INSTR = 4'd0,
        DECODE      = 4'd1,
        MEM_ADDR    = 4'd2,
        MEM_READ    = 4'd3,
        MEM_WB      = 4'd4,
        MEM_WRITE   = 4'd5,
        EXECUTE     = 4'd6,
        ALU_WB      = 4'd7,
        BRANCH      = 4'd8,
        JUMP        = 4'd9
    } state_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DONE  = 2'd2,
        FAULT = 2'd3
    } fetch_state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE       = 2'b00,
        CAUSE_MISALIGNED = 2'b01,
        CAUSE_TIMEOUT    = 2'b10
    } fault_cause_t;

    localparam logic [3:0]  BYTEEN_WORD = 4'b1111;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;

    // Counter width able to hold 0..limit, never narrower than one bit.
    function automatic int unsigned wait_cnt_width(input int unsigned limit);
        int unsigned w;
        w = $clog2(limit + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_wait_timer
// Description : Saturating wait-state counter; flags the last allowed cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_wait_timer #(
    parameter int unsigned LIMIT = 1,
    parameter int unsigned WIDTH = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (en && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == LAST);

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Fetches one 32-bit instruction over Avalon-MM per request.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter logic [31:0] RESET_INSTR    = NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic [31:0] pc,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic [3:0]  avm_byteenable,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        busy,
    output logic        fetch_fault,
    output logic [1:0]  fault_cause
);

    fetch_state_t state_q, state_d;
    fault_cause_t cause_q, cause_d;
    logic [31:0]  addr_q, addr_d;
    logic [31:0]  instr_q, instr_d;
    logic         wait_expired;

    generate
        if (TIMEOUT_CYCLES != 0) begin : g_timeout
            localparam int unsigned WAIT_W = wait_cnt_width(TIMEOUT_CYCLES);
            logic wait_clear;
            logic wait_en;

            // Counter rests at zero outside READ, so each bus cycle starts fresh.
            assign wait_clear = (state_q != READ);
            assign wait_en    = (state_q == READ) && avm_waitrequest;

            fetch_wait_timer #(
                .LIMIT (TIMEOUT_CYCLES),
                .WIDTH (WAIT_W)
            ) u_wait_timer (
                .clk     (clk),
                .reset   (reset),
                .clear   (wait_clear),
                .en      (wait_en),
                .expired (wait_expired)
            );
        end else begin : g_no_timeout
            assign wait_expired = 1'b0;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        case (state_q)
            IDLE: begin
                if (fetch_req) begin
                    addr_d = pc;
                    if (pc[1:0] != 2'b00) begin
                        state_d = FAULT;
                        cause_d = CAUSE_MISALIGNED;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                if (!avm_waitrequest) begin
                    instr_d = avm_readdata;
                    state_d = DONE;
                end else if (wait_expired) begin
                    state_d = FAULT;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            DONE:    state_d = IDLE;
            FAULT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cause_q <= CAUSE_NONE;
            addr_q  <= '0;
            instr_q <= RESET_INSTR;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
        end
    end

    // Every output comes from a flop or a state decode; no bus-input feedthrough.
    assign avm_read       = (state_q == READ);
    assign avm_address    = addr_q;
    assign avm_byteenable = avm_read ? BYTEEN_WORD : 4'b0000;
    assign instr          = instr_q;
    assign instr_valid    = (state_q == DONE);
    assign fetch_fault    = (state_q == FAULT);
    assign busy           = (state_q != IDLE);
    assign fault_cause    = cause_q;

endmodule
`default_nettype wire
